// File: rtl/sapho_pkg.sv
// Shared definitions for the processor data stack.
// Provides default data width and stack depth, plus the bit positions of the
// packed status/debug word that the stack exposes alongside its plain flags.
package sapho_pkg;

    localparam int DEF_NBDATA = 32;
    localparam int DEF_SDEPTH = 16;

    // Bit positions inside the stack status word.
    localparam int ST_OVF   = 0;
    localparam int ST_UNF   = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_FULL  = 3;
    localparam int NBSTAT   = 4;

endpackage

// File: rtl/data_stack_if.sv
// Bundle between the instruction decoder (master) and the data stack (slave).
//
// Strobe semantics: push and pop are single-cycle command strobes with no
// ready/backpressure. The stack accepts a strobe on every rising edge it is
// high; a request that cannot be honoured (push when full, pop when empty)
// is dropped and recorded in the sticky ovf/unf flags instead of stalling.
//
// Signals:
//   push, pop  decoder -> stack command strobes
//   in         value to push (accumulator)
//   out        registered top-of-stack
//   level      number of valid entries
//   empty/full occupancy status
//   ovf/unf    sticky dropped-push / dropped-pop flags
//   status     packed {full, empty, unf, ovf} debug word
interface data_stack_if
    import sapho_pkg::*;
#(
    parameter int NBDATA = DEF_NBDATA,
    parameter int NBSPTR = $clog2(DEF_SDEPTH + 1)
);
    logic              push;
    logic              pop;
    logic [NBDATA-1:0] in;
    logic [NBDATA-1:0] out;
    logic [NBSPTR-1:0] level;
    logic              empty;
    logic              full;
    logic              ovf;
    logic              unf;
    logic [NBSTAT-1:0] status;

    modport master (
        output push, pop, in,
        input  out, level, empty, full, ovf, unf, status
    );

    modport slave (
        input  push, pop, in,
        output out, level, empty, full, ovf, unf, status
    );
endinterface

// File: rtl/stack_ram.sv
// Storage for the stack entries below the top register.
// Single clock, one synchronous write port, one combinational read port.
// Contents are not reset; the stack only reads addresses below its level.
//
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational)
module stack_ram #(
    parameter int NBDATA = 32,
    parameter int DEPTH  = 15,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [NBDATA-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [NBDATA-1:0] rdata
);

    logic [NBDATA-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_stack.sv
// Processor data stack fed by the decoder push/pop strobes.
// The top entry lives in a register (drives out); deeper entries live in
// stack_ram. Occupancy is tracked by a saturating level counter, and dropped
// requests set sticky ovf/unf flags that clear only on reset.
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  data_stack_if slave modport (push, pop, in, out, level, empty,
//        full, ovf, unf, status)
module data_stack
    import sapho_pkg::*;
#(
    parameter int NBDATA = DEF_NBDATA,
    parameter int SDEPTH = DEF_SDEPTH,
    parameter int NBSPTR = $clog2(SDEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    data_stack_if.slave  bus
);

    localparam int RDEPTH = SDEPTH - 1;
    localparam int AW     = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;

    localparam logic [NBSPTR-1:0] LVL_ONE  = NBSPTR'(1);
    localparam logic [NBSPTR-1:0] LVL_TWO  = NBSPTR'(2);
    localparam logic [NBSPTR-1:0] LVL_FULL = NBSPTR'(SDEPTH);

    logic [NBDATA-1:0] tos;
    logic [NBSPTR-1:0] lvl;
    logic              ovf_r;
    logic              unf_r;

    logic              is_empty;
    logic              is_full;
    logic [NBSPTR-1:0] lvl_m1;
    logic [NBSPTR-1:0] lvl_m2;
    logic              ram_we;
    logic [NBDATA-1:0] ram_rdata;

    assign is_empty = (lvl == '0);
    assign is_full  = (lvl == LVL_FULL);
    assign lvl_m1   = lvl - LVL_ONE;
    assign lvl_m2   = lvl - LVL_TWO;

    // The old top spills into RAM only on a real push onto a non-empty,
    // non-full stack; a push+pop replaces the top in place.
    assign ram_we = bus.push && !bus.pop && !is_full && !is_empty;

    stack_ram #(
        .NBDATA (NBDATA),
        .DEPTH  (RDEPTH),
        .AW     (AW)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .waddr  (lvl_m1[AW-1:0]),
        .wdata  (tos),
        .raddr  (lvl_m2[AW-1:0]),
        .rdata  (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tos   <= '0;
            lvl   <= '0;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else if (bus.push && bus.pop && !is_empty) begin
            // Replace-top: level, RAM and flags untouched, even when full.
            tos <= bus.in;
        end else if (bus.push) begin
            // Plain push, or push+pop on an empty stack (behaves as push).
            if (is_full) begin
                ovf_r <= 1'b1;
            end else begin
                tos <= bus.in;
                lvl <= lvl + LVL_ONE;
            end
        end else if (bus.pop) begin
            if (is_empty) begin
                unf_r <= 1'b1;
            end else if (lvl == LVL_ONE) begin
                tos <= '0;
                lvl <= '0;
            end else begin
                tos <= ram_rdata;
                lvl <= lvl_m1;
            end
        end
    end

    assign bus.out   = tos;
    assign bus.level = lvl;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.ovf   = ovf_r;
    assign bus.unf   = unf_r;

    always_comb begin
        bus.status           = '0;
        bus.status[ST_OVF]   = ovf_r;
        bus.status[ST_UNF]   = unf_r;
        bus.status[ST_EMPTY] = is_empty;
        bus.status[ST_FULL]  = is_full;
    end

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack (NBDATA=32, SDEPTH=16).
module tb_data_stack;
    import sapho_pkg::*;

    localparam int NBDATA = 32;
    localparam int SDEPTH = 16;
    localparam int NBSPTR = $clog2(SDEPTH + 1);

    logic clk;
    logic rst;

    data_stack_if #(.NBDATA(NBDATA), .NBSPTR(NBSPTR)) bus ();

    data_stack #(
        .NBDATA (NBDATA),
        .SDEPTH (SDEPTH),
        .NBSPTR (NBSPTR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    // comparison helpers
    task automatic cmp(input string name, input logic [NBDATA-1:0] act, input logic [NBDATA-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check(input string name, input logic [NBDATA-1:0] e_out, input int e_lvl,
                         input bit e_ovf, input bit e_unf);
        logic [NBSTAT-1:0] e_stat;
        bit e_empty;
        bit e_full;
        e_empty = (e_lvl == 0);
        e_full  = (e_lvl == SDEPTH);
        e_stat  = {e_full, e_empty, e_unf, e_ovf};
        cmp({name, ".out"},    bus.out, e_out);
        cmp({name, ".level"},  NBDATA'(bus.level), NBDATA'(e_lvl));
        cmp({name, ".empty"},  NBDATA'(bus.empty), NBDATA'(e_empty));
        cmp({name, ".full"},   NBDATA'(bus.full), NBDATA'(e_full));
        cmp({name, ".ovf"},    NBDATA'(bus.ovf), NBDATA'(e_ovf));
        cmp({name, ".unf"},    NBDATA'(bus.unf), NBDATA'(e_unf));
        cmp({name, ".status"}, NBDATA'(bus.status), NBDATA'(e_stat));
    endtask

    // driver: strobe for exactly one rising edge, outputs settle #1 after it
    task automatic step(input bit p_push, input bit p_pop, input logic [NBDATA-1:0] p_in);
        @(negedge clk);
        bus.push = p_push;
        bus.pop  = p_pop;
        bus.in   = p_in;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.in   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit                push;
        bit                pop;
        logic [NBDATA-1:0] din;
        logic [NBDATA-1:0] e_out;
        int                e_lvl;
        bit                e_ovf;
        bit                e_unf;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // push 1,2,3 then three pops
        vecs[0]  = '{1'b1, 1'b0, 32'd1,    32'd1,    1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'd2,    32'd2,    2, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'd3,    32'd3,    3, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'd0,    32'd2,    2, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'd0,    32'd1,    1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'd0,    32'd0,    0, 1'b0, 1'b0};
        // simultaneous push+pop
        vecs[6]  = '{1'b1, 1'b0, 32'd7,    32'd7,    1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'd9,    32'd9,    2, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'h33,   32'h33,   2, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'd0,    32'd7,    1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'd0,    32'd0,    0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 32'd4,    32'd4,    1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 32'd0,    32'd0,    0, 1'b0, 1'b0};
        // underflow, sticky through a later push
        vecs[13] = '{1'b0, 1'b1, 32'd0,    32'd0,    0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 32'd5,    32'd5,    1, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 32'd0,    32'd0,    0, 1'b0, 1'b1};

        rst      = 1'b1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.in   = '0;
        #1;
        check("reset_async", 32'd0, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset then idle
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, '0);
            check($sformatf("idle%0d", i), 32'd0, 0, 1'b0, 1'b0);
        end

        // vector table
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].din);
            check($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_lvl, vecs[i].e_ovf, vecs[i].e_unf);
        end

        // overflow on a fresh stack
        do_reset();
        check("ovf_reset", 32'd0, 0, 1'b0, 1'b0);
        for (int i = 0; i < SDEPTH; i++) begin
            step(1'b1, 1'b0, NBDATA'(32'h10 + i));
            check($sformatf("fill%0d", i), NBDATA'(32'h10 + i), i + 1, 1'b0, 1'b0);
        end
        // replace-top while full must not raise ovf
        step(1'b1, 1'b1, 32'h5F);
        check("full_replace", 32'h5F, SDEPTH, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hAA);
        check("ovf_push", 32'h5F, SDEPTH, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0);
        check("ovf_hold", 32'h5F, SDEPTH, 1'b1, 1'b0);
        // drain: replaced top first, then 0x1E..0x10, then empty
        for (int i = SDEPTH - 2; i >= 0; i--) begin
            step(1'b0, 1'b1, '0);
            check($sformatf("drain%0d", i), NBDATA'(32'h10 + i), i + 1, 1'b1, 1'b0);
        end
        step(1'b0, 1'b1, '0);
        check("drain_last", 32'd0, 0, 1'b1, 1'b0);
        step(1'b0, 1'b1, '0);
        check("drain_unf", 32'd0, 0, 1'b1, 1'b1);

        // reset mid-sequence, asserted between edges
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, NBDATA'(32'h40 + i));
        end
        check("pre_midrst", 32'h44, 5, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst", 32'd0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, '0);
        check("midrst_pop", 32'd0, 0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
